// File: rtl/ifu_fetch_queue.sv
// Fetch-to-decode decoupling queue: accepts up to two instructions per cycle from the
// I-cache fetch pair and presents the two oldest, in program order, to the decode IB.

`ifndef LA64_PC_WIDTH
`define LA64_PC_WIDTH 64
`endif

module ifu_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = `LA64_PC_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fch_valid,
    input  logic [1:0]        fch_mask,
    input  logic [PC_W-2:0]   fch_pc,
    input  logic [31:0]       fch_inst0,
    input  logic [31:0]       fch_inst1,
    input  logic              fch_err,
    output logic              fch_ready,
    input  logic              flush,
    output logic              ifu_i0_valid,
    output logic              ifu_i1_valid,
    output logic [PC_W-2:0]   ifu_i0_pc,
    output logic [PC_W-2:0]   ifu_i1_pc,
    output logic [31:0]       ifu_i0_inst,
    output logic [31:0]       ifu_i1_inst,
    output logic              ifu_i0_err,
    output logic              ifu_i1_err,
    input  logic [1:0]        ib_pop
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_W + 32;   // {err, pc[PC_W-2:0], inst}

    logic [EW-1:0]   mem_r [DEPTH];
    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;
    logic [AW:0]     count_s;
    logic [AW:0]     pop_s;
    logic [AW:0]     wr_num_s;
    logic            wr_en_s;
    logic [AW-1:0]   wr_idx0_s;
    logic [AW-1:0]   wr_idx1_s;
    logic [AW-1:0]   rd_idx0_s;
    logic [AW-1:0]   rd_idx1_s;
    logic [EW-1:0]   slot0_ent_s;
    logic [EW-1:0]   slot1_ent_s;
    logic [EW-1:0]   first_ent_s;
    logic [EW-1:0]   rd0_ent_s;
    logic [EW-1:0]   rd1_ent_s;

    // Occupancy, write acceptance, pop clamp and entry formatting.
    always_comb begin
        count_s     = wr_ptr_r - rd_ptr_r;
        fch_ready   = (count_s <= (AW+1)'(DEPTH - 2));
        wr_en_s     = fch_valid & fch_ready & ~flush;
        slot0_ent_s = {fch_err, fch_pc, fch_inst0};
        slot1_ent_s = {fch_err, fch_pc + (PC_W-1)'(2), fch_inst1};
        if (wr_en_s) begin
            wr_num_s = (AW+1)'(fch_mask[0]) + (AW+1)'(fch_mask[1]);
        end else begin
            wr_num_s = {(AW+1){1'b0}};
        end
        // A lone slot-1 fetch lands in the first free entry.
        if (fch_mask[0]) begin
            first_ent_s = slot0_ent_s;
        end else begin
            first_ent_s = slot1_ent_s;
        end
        if ((AW+1)'(ib_pop) > count_s) begin
            pop_s = count_s;
        end else begin
            pop_s = (AW+1)'(ib_pop);
        end
        wr_idx0_s = wr_ptr_r[AW-1:0];
        wr_idx1_s = wr_ptr_r[AW-1:0] + AW'(1);
        rd_idx0_s = rd_ptr_r[AW-1:0];
        rd_idx1_s = rd_ptr_r[AW-1:0] + AW'(1);
    end

    // Entry storage; deliberately never cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (wr_en_s && (fch_mask != 2'b00)) begin
            mem_r[wr_idx0_s] <= first_ent_s;
        end
        if (wr_en_s && (fch_mask == 2'b11)) begin
            mem_r[wr_idx1_s] <= slot1_ent_s;
        end
    end

    // Read/write pointers with wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + wr_num_s;
            rd_ptr_r <= rd_ptr_r + pop_s;
        end
    end

    // Output slots read straight from the two oldest entries.
    always_comb begin
        rd0_ent_s    = mem_r[rd_idx0_s];
        rd1_ent_s    = mem_r[rd_idx1_s];
        ifu_i0_valid = (count_s >= (AW+1)'(1));
        ifu_i1_valid = (count_s >= (AW+1)'(2));
        ifu_i0_err   = rd0_ent_s[EW-1];
        ifu_i0_pc    = rd0_ent_s[EW-2:32];
        ifu_i0_inst  = rd0_ent_s[31:0];
        ifu_i1_err   = rd1_ent_s[EW-1];
        ifu_i1_pc    = rd1_ent_s[EW-2:32];
        ifu_i1_inst  = rd1_ent_s[31:0];
    end

    ifu_fetch_queue_chk #(.AW(AW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .ib_pop(ib_pop),
        .count (count_s)
    );

endmodule

// Protocol checker: the decode IB must never consume more than is valid.
module ifu_fetch_queue_chk #(
    parameter int AW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  ib_pop,
    input  logic [AW:0] count
);

    a_pop_le_count: assert property (@(posedge clk) disable iff (!rst_n)
        (!flush) |-> ((AW+1)'(ib_pop) <= count));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: a queue-based reference model checked every cycle,
// plus hand-computed pinned expectations at key points of the stimulus.

module tb_ifu_fetch_queue;

    localparam int DEPTH = 8;
    localparam int PC_W  = 32;

    typedef struct {
        logic [PC_W-2:0] pc;
        logic [31:0]     inst;
        logic            err;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fch_valid;
    logic [1:0]        fch_mask;
    logic [PC_W-2:0]   fch_pc;
    logic [31:0]       fch_inst0;
    logic [31:0]       fch_inst1;
    logic              fch_err;
    logic              fch_ready;
    logic              flush;
    logic              ifu_i0_valid;
    logic              ifu_i1_valid;
    logic [PC_W-2:0]   ifu_i0_pc;
    logic [PC_W-2:0]   ifu_i1_pc;
    logic [31:0]       ifu_i0_inst;
    logic [31:0]       ifu_i1_inst;
    logic              ifu_i0_err;
    logic              ifu_i1_err;
    logic [1:0]        ib_pop;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Pinned literal expectations, raised by stimulus and checked by the compare process.
    logic            pin_en = 1'b0;
    int              pin_cnt;
    logic            pin_rdy;
    logic [PC_W-2:0] pin_pc0, pin_pc1;
    logic [31:0]     pin_in0, pin_in1;
    logic            pin_er0, pin_er1;

    ifu_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fch_valid   (fch_valid),
        .fch_mask    (fch_mask),
        .fch_pc      (fch_pc),
        .fch_inst0   (fch_inst0),
        .fch_inst1   (fch_inst1),
        .fch_err     (fch_err),
        .fch_ready   (fch_ready),
        .flush       (flush),
        .ifu_i0_valid(ifu_i0_valid),
        .ifu_i1_valid(ifu_i1_valid),
        .ifu_i0_pc   (ifu_i0_pc),
        .ifu_i1_pc   (ifu_i1_pc),
        .ifu_i0_inst (ifu_i0_inst),
        .ifu_i1_inst (ifu_i1_inst),
        .ifu_i0_err  (ifu_i0_err),
        .ifu_i1_err  (ifu_i1_err),
        .ib_pop      (ib_pop)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered queue of instructions.
    always @(posedge clk or negedge rst_n) begin : model
        automatic int  n;
        automatic bit  rdy;
        ent_t e;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            n   = q.size();
            rdy = (n <= DEPTH - 2);
            for (int i = 0; i < int'(ib_pop); i++) begin
                if (q.size() > 0) void'(q.pop_front());
            end
            if (fch_valid && rdy) begin
                if (fch_mask[0]) begin
                    e.pc = fch_pc; e.inst = fch_inst0; e.err = fch_err;
                    q.push_back(e);
                end
                if (fch_mask[1]) begin
                    e.pc = fch_pc + 31'd2; e.inst = fch_inst1; e.err = fch_err;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare process: DUT against the model every cycle, plus pinned literals.
    always @(negedge clk) begin : compare
        chk("i0_valid", 64'(ifu_i0_valid), 64'(q.size() >= 1));
        chk("i1_valid", 64'(ifu_i1_valid), 64'(q.size() >= 2));
        chk("fch_ready", 64'(fch_ready), 64'(q.size() <= DEPTH - 2));
        if (q.size() >= 1) begin
            chk("i0_pc", 64'(ifu_i0_pc), 64'(q[0].pc));
            chk("i0_inst", 64'(ifu_i0_inst), 64'(q[0].inst));
            chk("i0_err", 64'(ifu_i0_err), 64'(q[0].err));
        end
        if (q.size() >= 2) begin
            chk("i1_pc", 64'(ifu_i1_pc), 64'(q[1].pc));
            chk("i1_inst", 64'(ifu_i1_inst), 64'(q[1].inst));
            chk("i1_err", 64'(ifu_i1_err), 64'(q[1].err));
        end
        if (pin_en) begin
            chk("pin_count", 64'(q.size()), 64'(pin_cnt));
            chk("pin_ready", 64'(fch_ready), 64'(pin_rdy));
            chk("pin_i0_valid", 64'(ifu_i0_valid), 64'(pin_cnt >= 1));
            chk("pin_i1_valid", 64'(ifu_i1_valid), 64'(pin_cnt >= 2));
            if (pin_cnt >= 1) begin
                chk("pin_i0_pc", 64'(ifu_i0_pc), 64'(pin_pc0));
                chk("pin_i0_inst", 64'(ifu_i0_inst), 64'(pin_in0));
                chk("pin_i0_err", 64'(ifu_i0_err), 64'(pin_er0));
            end
            if (pin_cnt >= 2) begin
                chk("pin_i1_pc", 64'(ifu_i1_pc), 64'(pin_pc1));
                chk("pin_i1_inst", 64'(ifu_i1_inst), 64'(pin_in1));
                chk("pin_i1_err", 64'(ifu_i1_err), 64'(pin_er1));
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] m, input logic [30:0] pc,
                         input logic [31:0] i0, input logic [31:0] i1, input logic er,
                         input logic [1:0] pop, input logic fl);
        fch_valid = v; fch_mask = m; fch_pc = pc; fch_inst0 = i0; fch_inst1 = i1;
        fch_err = er; ib_pop = pop; flush = fl;
        @(posedge clk);
        #1;
        pin_en    = 1'b0;
        fch_valid = 1'b0; fch_mask = 2'b00; ib_pop = 2'd0; flush = 1'b0; fch_err = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 31'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic pin(input int cnt, input logic rdy, input logic [30:0] pc0, input logic [31:0] in0,
                       input logic [30:0] pc1, input logic [31:0] in1, input logic e0, input logic e1);
        pin_cnt = cnt; pin_rdy = rdy; pin_pc0 = pc0; pin_in0 = in0;
        pin_pc1 = pc1; pin_in1 = in1; pin_er0 = e0; pin_er1 = e1; pin_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        fch_valid = 1'b0; fch_mask = 2'b00; fch_pc = 31'd0; fch_inst0 = 32'd0;
        fch_inst1 = 32'd0; fch_err = 1'b0; ib_pop = 2'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pin(0, 1'b1, 31'd0, 32'd0, 31'd0, 32'd0, 1'b0, 1'b0);
        idle();

        // First pair into an empty queue: visible the next cycle.
        drive(1'b1, 2'b11, 31'h800, 32'hA, 32'hB, 1'b0, 2'd0, 1'b0);
        pin(2, 1'b1, 31'h800, 32'hA, 31'h802, 32'hB, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 31'd0, 32'd0, 32'd0, 1'b0, 2'd2, 1'b0);
        pin(0, 1'b1, 31'd0, 32'd0, 31'd0, 32'd0, 1'b0, 1'b0);

        // Fill with four pairs; the fifth is dropped; a pop of 2 reopens the queue.
        for (int k = 0; k < 4; k++)
            drive(1'b1, 2'b11, 31'(32'h100 + 4 * k), 32'h10 + 32'(2 * k), 32'h11 + 32'(2 * k), 1'b0, 2'd0, 1'b0);
        pin(8, 1'b0, 31'h100, 32'h10, 31'h102, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 31'h200, 32'hEE, 32'hEF, 1'b0, 2'd0, 1'b0);
        pin(8, 1'b0, 31'h100, 32'h10, 31'h102, 32'h11, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 31'd0, 32'd0, 32'd0, 1'b0, 2'd2, 1'b0);
        pin(6, 1'b1, 31'h104, 32'h12, 31'h106, 32'h13, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 31'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b1);
        pin(0, 1'b1, 31'd0, 32'd0, 31'd0, 32'd0, 1'b0, 1'b0);

        // Slot-1-only fetch makes one entry at pc+2.
        drive(1'b1, 2'b10, 31'h900, 32'h55, 32'hC, 1'b0, 2'd0, 1'b0);
        pin(1, 1'b1, 31'h902, 32'hC, 31'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 31'd0, 32'd0, 32'd0, 1'b0, 2'd1, 1'b0);

        // Steady state from an odd pointer: write pair + pop 2 across several wraps.
        drive(1'b1, 2'b11, 31'h300, 32'h30, 32'h31, 1'b0, 2'd0, 1'b0);
        for (int j = 1; j <= 20; j++)
            drive(1'b1, 2'b11, 31'(32'h300 + 4 * j), 32'h30 + 32'(2 * j), 32'h31 + 32'(2 * j), 1'b0, 2'd2, 1'b0);
        pin(2, 1'b1, 31'h350, 32'h58, 31'h352, 32'h59, 1'b0, 1'b0);

        // Write pair + pop 1: occupancy grows until fch_ready drops.
        for (int j = 0; j < 5; j++)
            drive(1'b1, 2'b11, 31'(32'h400 + 4 * j), 32'h60 + 32'(2 * j), 32'h61 + 32'(2 * j), 1'b0, 2'd1, 1'b0);
        pin(7, 1'b0, 31'h406, 32'h63, 31'h408, 32'h64, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 31'd0, 32'd0, 32'd0, 1'b0, 2'd2, 1'b0);
        pin(5, 1'b1, 31'h40A, 32'h65, 31'h40C, 32'h66, 1'b0, 1'b0);

        // Flush together with a write and a pop: the pair never appears.
        drive(1'b1, 2'b11, 31'h500, 32'h70, 32'h71, 1'b0, 2'd1, 1'b1);
        pin(0, 1'b1, 31'd0, 32'd0, 31'd0, 32'd0, 1'b0, 1'b0);
        idle();
        pin(0, 1'b1, 31'd0, 32'd0, 31'd0, 32'd0, 1'b0, 1'b0);

        // Fetch fault tags both instructions of the pair.
        drive(1'b1, 2'b11, 31'h600, 32'h80, 32'h81, 1'b1, 2'd0, 1'b0);
        pin(2, 1'b1, 31'h600, 32'h80, 31'h602, 32'h81, 1'b1, 1'b1);
        drive(1'b1, 2'b11, 31'h610, 32'h90, 32'h91, 1'b0, 2'd0, 1'b0);

        // Asynchronous reset mid-stream, checked before the next clock edge.
        #1;
        rst_n = 1'b0;
        pin(0, 1'b1, 31'd0, 32'd0, 31'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        pin_en = 1'b0;
        rst_n  = 1'b1;
        drive(1'b1, 2'b01, 31'h700, 32'hA0, 32'hA1, 1'b0, 2'd0, 1'b0);
        pin(1, 1'b1, 31'h700, 32'hA0, 31'd0, 32'd0, 1'b0, 1'b0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
